// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding and start-acceptance helper for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A new request is only taken when no operation is in flight.
    function automatic logic start_accepted(input state_e state, input logic start);
        return start && ((state == S_IDLE) || (state == S_DONE));
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - gate-level one-bit full adder cell
module full_adder (
    input  wire A,
    input  wire B,
    input  wire C,
    output wire Carry,
    output wire Sum
);

    wire ab_x;
    wire ab_a;
    wire c_a;

    xor g_x0 (ab_x, A, B);
    xor g_x1 (Sum, ab_x, C);
    and g_a0 (ab_a, A, B);
    and g_a1 (c_a, ab_x, C);
    or  g_o0 (Carry, ab_a, c_a);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               cell_carry;
    logic               cell_sum;
    logic [WIDTH-1:0]   sum_shift;

    full_adder u_cell (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .C     (carry_q),
        .Carry (cell_carry),
        .Sum   (cell_sum)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign sum_shift = WIDTH'({cell_sum, sum_sr_q} >> 1);

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accepted(state_q, start)) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d  = cell_carry;
                sum_sr_d = sum_shift;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_shift;
                    cout_d  = cell_carry;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    typedef struct {
        logic [8:0] val;
        int         due;
    } exp_t;

    exp_t       q8[$];
    exp_t       q2[$];
    exp_t       e8, e2;
    logic [8:0] hold8 = '0;
    logic [2:0] hold2 = '0;
    int         blen8 = 0;
    int         blen2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned addition, done expected WIDTH+1 edges after the drive point.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t e;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        e.val = {1'b0, a} + {1'b0, b} + 9'(c);
        e.due = cyc + 1 + 8;
        q8.push_back(e);
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
        exp_t e;
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        e.val = 9'(int'(a) + int'(b) + int'(c));
        e.due = cyc + 1 + 2;
        q2.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain8;
        for (int i = 0; i < 60 && q8.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain8_pending", q8.size(), 0);
        q8.delete();
    endtask

    task automatic drain2;
        for (int i = 0; i < 20 && q2.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain2_pending", q2.size(), 0);
        q2.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 1, 0);
                end else begin
                    e8 = q8.pop_front();
                    chk("sum8", sum8, e8.val[7:0]);
                    chk("cout8", cout8, e8.val[8]);
                    chk("latency8", cyc, e8.due);
                    chk("busy8_len", blen8, 8);
                    hold8 = e8.val;
                end
                blen8 = 0;
            end else begin
                chk("hold8", {cout8, sum8}, hold8);
                if (busy8) blen8++;
                else       blen8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("done2_unexpected", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    chk("sum2", sum2, e2.val[1:0]);
                    chk("cout2", cout2, e2.val[2]);
                    chk("latency2", cyc, e2.due);
                    chk("busy2_len", blen2, 2);
                    hold2 = e2.val[2:0];
                end
                blen2 = 0;
            end else begin
                chk("hold2", {cout2, sum2}, hold2);
                if (busy2) blen2++;
                else       blen2 = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) step();
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_sum2", {cout2, sum2}, 0);
        rst = 1'b0;
        step();

        issue8(8'h5A, 8'h3C, 1'b0); step(); start8 = 1'b0; drain8();
        issue8(8'hFF, 8'h01, 1'b0); step(); start8 = 1'b0; drain8();
        issue8(8'hFF, 8'hFF, 1'b1); step(); start8 = 1'b0; drain8();

        // Start during RUN must be dropped; operands also scrambled mid-run.
        issue8(8'h5A, 8'h3C, 1'b0); step(); start8 = 1'b0;
        repeat (2) step();
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
        step(); start8 = 1'b0;
        drain8();

        // Abort mid-RUN.
        issue8(8'($urandom), 8'($urandom), 1'($urandom)); step(); start8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q8.delete();
        hold8 = '0;
        hold2 = '0;
        chk("abort_busy8", busy8, 0);
        chk("abort_done8", done8, 0);
        chk("abort_sum8", sum8, 0);
        chk("abort_cout8", cout8, 0);
        repeat (2) step();
        issue8(8'h10, 8'h20, 1'b0); step(); start8 = 1'b0; drain8();

        repeat (10) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom)); step(); start8 = 1'b0; drain8();
        end

        // Start held high: a new operand set is presented each WIDTH+1 cycles.
        for (int k = 0; k < 6; k++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat (9) step();
        end
        start8 = 1'b0;
        drain8();

        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    issue2(2'(ia), 2'(ib), 1'(ic)); step(); start2 = 1'b0; drain2();
                end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
